// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
interface dmem_responder_if #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
);
  logic                  req_rd;
  logic                  req_wr;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic [2:0]            funct3;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  busy;
  logic                  err;
  logic [7:0]            err_cnt;

  modport master (
    output req_rd, req_wr, addr, wdata, funct3,
    input  rdata, rvalid, busy, err, err_cnt
  );

  modport slave (
    input  req_rd, req_wr, addr, wdata, funct3,
    output rdata, rvalid, busy, err, err_cnt
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed data memory with configurable read latency, RV32I sub-word
// loads/stores, and misalignment/illegal-request error counting.
module dmem_responder #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned IDX_W = DM_ADDRESS - 2;
  localparam int unsigned WORDS = 1 << IDX_W;
  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned ERR_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DM_ADDRESS-1:0] cap_addr, cap_addr_n;
  logic [2:0]            cap_f3, cap_f3_n;
  logic [DATA_W-1:0]     rdata_q, rdata_n;
  logic                  rvalid_q, rvalid_n;
  logic                  err_q, err_n;
  logic [ERR_W-1:0]      err_cnt_q, err_cnt_n;

  logic [DATA_W-1:0]     mem [WORDS];

  logic                  rd_legal, wr_legal, misaligned, err_ev, rd_go, wr_go;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [2:0]            sel_f3;
  logic [DATA_W-1:0]     rword;
  logic [LANES-1:0]      wmask;
  logic [DATA_W-1:0]     wdat;

  // Extract the addressed byte/half/word and extend by funct3[2].
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] w,
                                                 input logic [1:0]        lane,
                                                 input logic [2:0]        f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lane, 3'b000});
    h = 16'(w >> {lane[1], 4'b0000});
    case (f3[1:0])
      2'b00:   load_ext = f3[2] ? DATA_W'(b) : {{(DATA_W-8){b[7]}}, b};
      2'b01:   load_ext = f3[2] ? DATA_W'(h) : {{(DATA_W-16){h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  // Request qualification; errors are only recognised while idle.
  always_comb begin
    rd_legal   = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    wr_legal   = bus.funct3 inside {3'b000, 3'b001, 3'b010};
    misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    err_ev     = (state == S_IDLE) &&
                 ((bus.req_rd && bus.req_wr) ||
                  (bus.req_rd && (!rd_legal || misaligned)) ||
                  (bus.req_wr && (!wr_legal || misaligned)));
    rd_go      = (state == S_IDLE) && bus.req_rd && !err_ev;
    wr_go      = (state == S_IDLE) && bus.req_wr && !err_ev;
  end

  // With RD_LAT=1 the response is formed from the live request.
  always_comb begin
    sel_addr = (state == S_IDLE) ? bus.addr : cap_addr;
    sel_f3   = (state == S_IDLE) ? bus.funct3 : cap_f3;
    rword    = mem[sel_addr[DM_ADDRESS-1:2]];
  end

  always_comb begin
    wmask = '1;
    wdat  = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        wmask = LANES'(1) << bus.addr[1:0];
        wdat  = {LANES{bus.wdata[7:0]}};
      end
      2'b01: begin
        wmask = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdat  = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cap_addr_n = cap_addr;
    cap_f3_n   = cap_f3;
    rdata_n    = rdata_q;
    rvalid_n   = 1'b0;
    err_n      = err_ev;
    err_cnt_n  = err_cnt_q;
    if (err_ev && (err_cnt_q != '1)) err_cnt_n = err_cnt_q + ERR_W'(1);
    case (state)
      S_IDLE: begin
        if (rd_go) begin
          cap_addr_n = bus.addr;
          cap_f3_n   = bus.funct3;
          cnt_n      = CNT_W'(RD_LAT - 1);
          state_n    = (RD_LAT == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = S_RESP;
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (state_n == S_RESP) begin
      rvalid_n = 1'b1;
      rdata_n  = load_ext(rword, sel_addr[1:0], sel_f3);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_f3    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cap_addr  <= cap_addr_n;
      cap_f3    <= cap_f3_n;
      rdata_q   <= rdata_n;
      rvalid_q  <= rvalid_n;
      err_q     <= err_n;
      err_cnt_q <= err_cnt_n;
    end
  end

  // Storage is not reset; stores are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (wr_go && !reset) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) mem[bus.addr[DM_ADDRESS-1:2]][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.busy    = rd_go || (state == S_WAIT);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at read latencies 1, 2 and 4.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) b1 ();
  dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) b2 ();
  dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) b4 ();

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));

  task automatic drv(input int d, input logic rd, input logic wr, input logic [8:0] a,
                     input logic [31:0] wd, input logic [2:0] f3);
    case (d)
      1: begin b1.req_rd = rd; b1.req_wr = wr; b1.addr = a; b1.wdata = wd; b1.funct3 = f3; end
      2: begin b2.req_rd = rd; b2.req_wr = wr; b2.addr = a; b2.wdata = wd; b2.funct3 = f3; end
      default: begin b4.req_rd = rd; b4.req_wr = wr; b4.addr = a; b4.wdata = wd; b4.funct3 = f3; end
    endcase
  endtask

  function automatic logic g_busy(input int d);
    case (d) 1: return b1.busy; 2: return b2.busy; default: return b4.busy; endcase
  endfunction
  function automatic logic g_rvalid(input int d);
    case (d) 1: return b1.rvalid; 2: return b2.rvalid; default: return b4.rvalid; endcase
  endfunction
  function automatic logic [31:0] g_rdata(input int d);
    case (d) 1: return b1.rdata; 2: return b2.rdata; default: return b4.rdata; endcase
  endfunction
  function automatic logic g_err(input int d);
    case (d) 1: return b1.err; 2: return b2.err; default: return b4.err; endcase
  endfunction
  function automatic logic [7:0] g_cnt(input int d);
    case (d) 1: return b1.err_cnt; 2: return b2.err_cnt; default: return b4.err_cnt; endcase
  endfunction

  // All tasks start and end one time unit after a rising edge.
  task automatic store(input int d, input logic [8:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output logic bsy);
    drv(d, 1'b0, 1'b1, a, wd, f3);
    #1 bsy = g_busy(d);
    @(posedge clk); #1;
    drv(d, 1'b0, 1'b0, 9'h0, 32'h0, 3'b010);
  endtask

  // Hold a load request as a stalled pipeline would, until rvalid or timeout.
  task automatic load(input int d, input logic [8:0] a, input logic [2:0] f3,
                      output logic [31:0] data, output int nbusy, output int lat);
    nbusy = 0;
    lat   = -1;
    data  = 32'hxxxx_xxxx;
    drv(d, 1'b1, 1'b0, a, 32'h0, f3);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (g_rvalid(d)) begin
        lat  = c;
        data = g_rdata(d);
        break;
      end
      if (g_busy(d)) nbusy++;
      @(posedge clk); #1;
    end
    drv(d, 1'b0, 1'b0, 9'h0, 32'h0, 3'b010);
    @(posedge clk); #1;
  endtask

  // One-cycle erroneous request; observe busy, err pulse and count.
  task automatic bad(input int d, input logic rd, input logic wr, input logic [8:0] a,
                     input logic [2:0] f3, output logic bsy, output logic e1,
                     output logic e2, output logic [7:0] cnt);
    drv(d, rd, wr, a, 32'h0000_BEEF, f3);
    #1 bsy = g_busy(d);
    @(posedge clk); #1;
    drv(d, 1'b0, 1'b0, 9'h0, 32'h0, 3'b010);
    e1  = g_err(d);
    cnt = g_cnt(d);
    @(posedge clk); #1;
    e2 = g_err(d);
  endtask

  task automatic test_reset();
    for (int d = 1; d <= 4; d++) drv(d, 1'b0, 1'b0, 9'h0, 32'h0, 3'b010);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int d = 1; d <= 4; d *= 2) begin
      n_tests++; if (g_rdata(d) !== 32'h0) begin n_fail++; $display("FAIL reset_rdata d%0d: got %h want 0", d, g_rdata(d)); end
      n_tests++; if ({g_rvalid(d), g_busy(d), g_err(d)} !== 3'b000) begin n_fail++; $display("FAIL reset_flags d%0d: got %b want 000", d, {g_rvalid(d), g_busy(d), g_err(d)}); end
      n_tests++; if (g_cnt(d) !== 8'h0) begin n_fail++; $display("FAIL reset_errcnt d%0d: got %0d want 0", d, g_cnt(d)); end
    end
  endtask

  task automatic test_word();
    logic [31:0] dat; int nb, lat; logic bsy;
    store(2, 9'h010, 32'h8765_4321, 3'b010, bsy);
    n_tests++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL sw_busy: got %b want 0", bsy); end
    load(2, 9'h010, 3'b010, dat, nb, lat);
    n_tests++; if (dat !== 32'h8765_4321) begin n_fail++; $display("FAIL lw_data: got %h want 87654321", dat); end
    n_tests++; if (nb != 2) begin n_fail++; $display("FAIL lw_busy_cycles: got %0d want 2", nb); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", lat); end
    n_tests++; if (b2.rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_one_shot: got %b want 0", b2.rvalid); end
    n_tests++; if (b2.rdata !== 32'h8765_4321) begin n_fail++; $display("FAIL rdata_hold: got %h want 87654321", b2.rdata); end
  endtask

  task automatic test_byte();
    logic [31:0] dat; int nb, lat; logic bsy;
    store(2, 9'h013, 32'h0000_00AB, 3'b000, bsy);
    load(2, 9'h010, 3'b010, dat, nb, lat);
    n_tests++; if (dat !== 32'hAB65_4321) begin n_fail++; $display("FAIL sb_lw: got %h want ab654321", dat); end
    load(2, 9'h013, 3'b000, dat, nb, lat);
    n_tests++; if (dat !== 32'hFFFF_FFAB) begin n_fail++; $display("FAIL lb_neg: got %h want ffffffab", dat); end
    load(2, 9'h013, 3'b100, dat, nb, lat);
    n_tests++; if (dat !== 32'h0000_00AB) begin n_fail++; $display("FAIL lbu: got %h want 000000ab", dat); end
    load(2, 9'h010, 3'b000, dat, nb, lat);
    n_tests++; if (dat !== 32'h0000_0021) begin n_fail++; $display("FAIL lb_pos: got %h want 00000021", dat); end
    load(2, 9'h012, 3'b001, dat, nb, lat);
    n_tests++; if (dat !== 32'hFFFF_AB65) begin n_fail++; $display("FAIL lh_upper: got %h want ffffab65", dat); end
  endtask

  task automatic test_half();
    logic [31:0] dat; int nb, lat; logic bsy;
    store(2, 9'h020, 32'h1122_3344, 3'b010, bsy);
    store(2, 9'h022, 32'hFFFF_8001, 3'b001, bsy);
    load(2, 9'h022, 3'b001, dat, nb, lat);
    n_tests++; if (dat !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh: got %h want ffff8001", dat); end
    load(2, 9'h022, 3'b101, dat, nb, lat);
    n_tests++; if (dat !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu: got %h want 00008001", dat); end
    load(2, 9'h020, 3'b010, dat, nb, lat);
    n_tests++; if (dat !== 32'h8001_3344) begin n_fail++; $display("FAIL sh_low_kept: got %h want 80013344", dat); end
  endtask

  task automatic test_errors();
    logic bsy, e1, e2; logic [7:0] cnt; logic [31:0] dat; int nb, lat;
    bad(2, 1'b1, 1'b0, 9'h011, 3'b010, bsy, e1, e2, cnt);
    n_tests++; if ({bsy, e1, e2, cnt} !== {3'b010, 8'd1}) begin n_fail++; $display("FAIL err_lw_misal: got busy/err/err+1/cnt %b%b%b/%0d want 010/1", bsy, e1, e2, cnt); end
    bad(2, 1'b0, 1'b1, 9'h023, 3'b001, bsy, e1, e2, cnt);
    n_tests++; if ({bsy, e1, e2, cnt} !== {3'b010, 8'd2}) begin n_fail++; $display("FAIL err_sh_misal: got busy/err/err+1/cnt %b%b%b/%0d want 010/2", bsy, e1, e2, cnt); end
    bad(2, 1'b1, 1'b1, 9'h020, 3'b010, bsy, e1, e2, cnt);
    n_tests++; if ({bsy, e1, e2, cnt} !== {3'b010, 8'd3}) begin n_fail++; $display("FAIL err_rd_wr: got busy/err/err+1/cnt %b%b%b/%0d want 010/3", bsy, e1, e2, cnt); end
    bad(2, 1'b1, 1'b0, 9'h020, 3'b011, bsy, e1, e2, cnt);
    n_tests++; if ({bsy, e1, e2, cnt} !== {3'b010, 8'd4}) begin n_fail++; $display("FAIL err_ld_f3: got busy/err/err+1/cnt %b%b%b/%0d want 010/4", bsy, e1, e2, cnt); end
    bad(2, 1'b0, 1'b1, 9'h020, 3'b100, bsy, e1, e2, cnt);
    n_tests++; if ({bsy, e1, e2, cnt} !== {3'b010, 8'd5}) begin n_fail++; $display("FAIL err_st_f3: got busy/err/err+1/cnt %b%b%b/%0d want 010/5", bsy, e1, e2, cnt); end
    load(2, 9'h020, 3'b010, dat, nb, lat);
    n_tests++; if (dat !== 32'h8001_3344) begin n_fail++; $display("FAIL err_no_write: got %h want 80013344", dat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dat; int nb, lat; logic bsy;
    store(1, 9'h000, 32'hCAFE_F00D, 3'b010, bsy);
    load(1, 9'h000, 3'b010, dat, nb, lat);
    n_tests++; if ({dat, nb, lat} !== {32'hCAFE_F00D, 32'd1, 32'd1}) begin n_fail++; $display("FAIL lat1_first: got %h busy=%0d lat=%0d want cafef00d 1 1", dat, nb, lat); end
    load(1, 9'h002, 3'b001, dat, nb, lat);
    n_tests++; if ({dat, nb, lat} !== {32'hFFFF_CAFE, 32'd1, 32'd1}) begin n_fail++; $display("FAIL lat1_b2b: got %h busy=%0d lat=%0d want ffffcafe 1 1", dat, nb, lat); end
  endtask

  task automatic test_saturate();
    drv(1, 1'b1, 1'b1, 9'h000, 32'h0, 3'b010);
    repeat (300) @(posedge clk);
    #1 drv(1, 1'b0, 1'b0, 9'h0, 32'h0, 3'b010);
    n_tests++; if ({b1.err, b1.err_cnt} !== {1'b1, 8'd255}) begin n_fail++; $display("FAIL sat_pulse: got err=%b cnt=%0d want 1 255", b1.err, b1.err_cnt); end
    @(posedge clk); #1;
    n_tests++; if ({b1.err, b1.err_cnt} !== {1'b0, 8'd255}) begin n_fail++; $display("FAIL sat_hold: got err=%b cnt=%0d want 0 255", b1.err, b1.err_cnt); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] dat; int nb, lat, nv; logic bsy, e1, e2; logic [7:0] cnt;
    store(4, 9'h040, 32'h1234_5678, 3'b010, bsy);
    load(4, 9'h040, 3'b010, dat, nb, lat);
    n_tests++; if ({dat, nb, lat} !== {32'h1234_5678, 32'd4, 32'd4}) begin n_fail++; $display("FAIL lat4_load: got %h busy=%0d lat=%0d want 12345678 4 4", dat, nb, lat); end
    bad(4, 1'b1, 1'b0, 9'h041, 3'b010, bsy, e1, e2, cnt);
    n_tests++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL lat4_err: got %0d want 1", cnt); end
    drv(4, 1'b1, 1'b0, 9'h040, 32'h0, 3'b010);
    @(posedge clk); #1;
    reset = 1'b1;
    drv(4, 1'b0, 1'b0, 9'h0, 32'h0, 3'b010);
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++; if (dut4.state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dut4.state); end
    n_tests++; if ({b4.busy, b4.err_cnt} !== {1'b0, 8'd0}) begin n_fail++; $display("FAIL rst_busy_cnt: got busy=%b cnt=%0d want 0 0", b4.busy, b4.err_cnt); end
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      if (b4.rvalid) nv++;
      @(posedge clk); #1;
    end
    n_tests++; if (nv != 0) begin n_fail++; $display("FAIL rst_no_resp: got %0d rvalid cycles want 0", nv); end
    load(4, 9'h040, 3'b010, dat, nb, lat);
    n_tests++; if ({dat, lat} !== {32'h1234_5678, 32'd4}) begin n_fail++; $display("FAIL rst_mem_kept: got %h lat=%0d want 12345678 4", dat, lat); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_saturate();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
